mine_scheduler: RTL and testbench
=================================

# mine_scheduler

Sequences the SHA-256 mining datapath on the mine clock domain. It splits a nonce range across `NUM_CORES` hash cores and issues one nonce per cycle to a free core using round-robin arbitration. It tracks which nonce each core holds, captures the first winning nonce, and reports found or exhausted status to the processor and UART path.

## Interface
Parameters:
- `NUM_CORES`, 4: number of hash cores served; 1 to 16.
- `PTR_W`, 2: width of the round-robin pointer; ceil(log2(`NUM_CORES`)), minimum 1.

Ports:
- `clock` in 1: mine clock.
- `reset` in 1: synchronous, active-low (`reset`==0 clears the block at the rising edge).
- `start` in 1: one-cycle pulse; accepted only in IDLE, FOUND or EXHAUSTED.
- `abort` in 1: one-cycle pulse; returns to IDLE from any state.
- `nonce_start` in 32: first nonce of the range, sampled on accepted `start`.
- `nonce_end` in 32: last nonce of the range (inclusive), sampled on accepted `start`.
- `core_issue` out `NUM_CORES`: one-hot, one-cycle pulse telling core i to begin.
- `core_nonce` out 32*`NUM_CORES`: slice i is the nonce held by core i; stable until the next issue to core i.
- `core_abort` out 1: one-cycle pulse telling all cores to drop their work.
- `core_done` in `NUM_CORES`: core i finished its nonce (one-cycle pulse).
- `core_hit` in `NUM_CORES`: qualified by `core_done[i]`; the hash met target.
- `busy` out 1: state is RUN or DRAIN.
- `found` out 1: state is FOUND.
- `exhausted` out 1: state is EXHAUSTED.
- `found_nonce` out 32: winning nonce; holds until the next accepted `start` or reset.
- `hashes_done` out 32: completed-hash count (see Configuration).

## Operation
- States: IDLE, RUN, DRAIN, FOUND, EXHAUSTED.
- Per-core `busy_vec[i]`:
  - Set on `core_issue[i]`.
  - Cleared on `core_done[i]`.
  - Core i is eligible when `busy_vec[i]`==0.
- IDLE: on `start`, latch `next_nonce`=`nonce_start` and `last`=`nonce_end`, clear `found_nonce`, go to RUN.
- RUN issue rule:
  - Each cycle, grant the first eligible core at or after `rr_ptr`, searching modulo `NUM_CORES`.
  - On a grant to core i: pulse `core_issue[i]`, load `core_nonce[i]`=`next_nonce`, set `rr_ptr`=(i+1) mod `NUM_CORES`, and increment `next_nonce` mod 2^32.
  - If there is no grant, `rr_ptr` holds.
- Range end:
  - When the issued nonce equals `last`, go to DRAIN and issue nothing more.
  - The range wraps through 0xFFFFFFFF to 0 when `nonce_end` < `nonce_start`.
  - `nonce_start`==`nonce_end` issues exactly one nonce.
- Hit handling (RUN or DRAIN): any `core_done[i]` && `core_hit[i]` does all of the following:
  - Sets `found_nonce`=`core_nonce[i]`.
  - Pulses `core_abort`.
  - Clears all `busy_vec`.
  - Goes to FOUND.
  - If several cores hit in the same cycle, the lowest index wins.
  - A hit takes priority over a same-cycle range-end transition.
  - No issue occurs in the cycle a hit is taken.
- DRAIN: when `busy_vec`==0 with no hit, go to EXHAUSTED.
- FOUND and EXHAUSTED: hold. `start` begins a new run; `abort` goes to IDLE.
- `abort` (any state):
  - Pulses `core_abort`, clears `busy_vec`, goes to IDLE.
  - Suppresses any same-cycle issue or hit capture.
  - `found_nonce` is retained.
- `core_done` for a core that is not busy is ignored.
- `core_done` arriving outside RUN and DRAIN is ignored.

## Timing
- Reset values (`reset`==0): state IDLE; `busy_vec`, `rr_ptr`, and all `core_nonce` slices 0; every output 0.
- All outputs are registered.
- Accepted `start` at edge t: RUN from t+1; first `core_issue` at t+1; with all cores free, one issue per cycle.
- Steady state: core i may be reissued in the cycle after its `core_done`.
- Hit latency: `core_done` and `core_hit` sampled at edge t give `found`=1, `found_nonce` valid, and `core_abort`=1, all at t+1.
- Range end: the last issue at edge t gives `busy`=1 in DRAIN from t+1. The last `core_done` at edge u gives `exhausted`=1 from u+1.
- `abort` at edge t: IDLE and `busy`=0 at t+1.
- `reset` low mid-run clears everything at the same edge, with no `core_abort` pulse. Cores are reset by the same `reset`.

## Configuration
- `MINE_SCHED_STATS_EN` defined:
  - `hashes_done` increments once per cycle in which any `core_done` bit is set among busy cores, by the popcount of those bits, saturating at 0xFFFFFFFF.
  - Cleared on reset and on accepted `start`.
- Not defined: `hashes_done` is tied to 0 and the counter logic is absent.

## Test plan
- Full issue order: `NUM_CORES`=4, `start` with range 0x100..0x107, cores complete 3 cycles after issue with no hit.
  - Issue order is cores 0,1,2,3 with nonces 0x100..0x103; then 0x104..0x107 as cores free up, round-robin.
  - `exhausted`=1 one cycle after the last done; `hashes_done`=8 when the macro is defined.
- Single hit: range 0x42A14690..0x42A1469F, hit asserted on the core holding 0x42A14695.
  - `found`=1 and `found_nonce`=0x42A14695 one cycle later.
  - `core_abort` pulses once; no further `core_issue`.
- Simultaneous hits: cores 1 and 3 hit in the same cycle, holding 0x11 and 0x13 → `found_nonce`=0x11.
- Wrap: range 0xFFFFFFFE..0x00000001 → issues 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1, then DRAIN.
- Abort mid-run: `abort` in RUN with 3 cores busy → `busy`=0 next cycle, one `core_abort`; a later `core_done` is ignored and the state stays IDLE.
- Reset: `reset`=0 for one cycle during DRAIN → all outputs 0 next cycle; a subsequent `start` with 0x5..0x5 issues exactly one nonce, 0x5, to core 0.

Source files
------------

// File: rtl/mine_scheduler.sv
// mine_scheduler: round-robin nonce issue to NUM_CORES hash cores.
// Optional completed-hash counter enabled by MINE_SCHED_STATS_EN.
module mine_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int PTR_W     = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [31:0]            nonce_start,
  input  logic [31:0]            nonce_end,
  output logic [NUM_CORES-1:0]   core_issue,
  output logic [32*NUM_CORES-1:0] core_nonce,
  output logic                   core_abort,
  input  logic [NUM_CORES-1:0]   core_done,
  input  logic [NUM_CORES-1:0]   core_hit,
  output logic                   busy,
  output logic                   found,
  output logic                   exhausted,
  output logic [31:0]            found_nonce,
  output logic [31:0]            hashes_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FOUND,
    S_EXH
  } state_t;

  state_t state;
  state_t state_nx;

  logic [NUM_CORES-1:0]       busy_vec;
  logic [NUM_CORES-1:0]       busy_vec_nx;
  logic [PTR_W-1:0]           rr_ptr;
  logic [PTR_W-1:0]           rr_ptr_nx;
  logic [31:0]                next_nonce;
  logic [31:0]                next_nonce_nx;
  logic [31:0]                last;
  logic [31:0]                last_nx;
  logic [NUM_CORES-1:0][31:0] nonce_q;
  logic [NUM_CORES-1:0]       issue_nx;
  logic                       abort_nx;
  logic [31:0]                found_nonce_nx;

  logic                 idle_like;
  logic                 live;
  logic                 start_ok;
  logic                 hit;
  logic                 do_issue;
  logic                 is_last;
  logic                 gnt_any;
  logic [PTR_W-1:0]     gnt_idx;
  logic [PTR_W-1:0]     hit_idx;
  logic [NUM_CORES-1:0] done_vec;
  logic [NUM_CORES-1:0] hit_vec;
  logic [31:0]          cur_nonce;
  logic [31:0]          cur_last;

  assign idle_like = (state == S_IDLE) ||
                     (state == S_FOUND) ||
                     (state == S_EXH);
  assign live      = (state == S_RUN) ||
                     (state == S_DRAIN);
  assign start_ok  = start && idle_like && !abort;
  // done from idle cores or outside a run is dropped
  assign done_vec  = live ? (core_done & busy_vec) : '0;
  assign hit_vec   = done_vec & core_hit;
  assign hit       = (|hit_vec) && !abort;
  // the start cycle issues from the freshly sampled range
  assign cur_nonce = start_ok ? nonce_start : next_nonce;
  assign cur_last  = start_ok ? nonce_end : last;
  assign do_issue  = gnt_any && !abort && !hit &&
                     (start_ok || (state == S_RUN));
  assign is_last   = do_issue && (cur_nonce == cur_last);

  // round-robin search for the first free core at or after rr_ptr
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= NUM_CORES) j = j - NUM_CORES;
      if (!busy_vec[j]) begin
        gnt_any = 1'b1;
        gnt_idx = PTR_W'(j);
      end
    end
  end

  // lowest-index hit wins
  always_comb begin
    hit_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_idx = PTR_W'(i);
    end
  end

  // state register with registered status flags
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      found     <= 1'b0;
      exhausted <= 1'b0;
    end else begin
      state     <= state_nx;
      busy      <= (state_nx == S_RUN) ||
                   (state_nx == S_DRAIN);
      found     <= (state_nx == S_FOUND);
      exhausted <= (state_nx == S_EXH);
    end
  end

  // next-state logic; abort overrides everything
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_FOUND, S_EXH: begin
        if (start_ok)
          state_nx = is_last ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        if (hit) state_nx = S_FOUND;
        else if (is_last) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (hit) state_nx = S_FOUND;
        else if ((busy_vec & ~done_vec) == '0)
          state_nx = S_EXH;
      end
      default: state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  // next values of the registered datapath outputs
  always_comb begin
    issue_nx = '0;
    if (do_issue) issue_nx[gnt_idx] = 1'b1;
    abort_nx = abort || hit;
    if (abort || hit)
      busy_vec_nx = '0;
    else
      busy_vec_nx = (busy_vec & ~done_vec) | issue_nx;
    rr_ptr_nx = rr_ptr;
    if (do_issue) begin
      if (gnt_idx == PTR_W'(NUM_CORES - 1))
        rr_ptr_nx = '0;
      else
        rr_ptr_nx = gnt_idx + PTR_W'(1);
    end
    next_nonce_nx = do_issue ? cur_nonce + 32'd1 : next_nonce;
    last_nx = start_ok ? nonce_end : last;
    found_nonce_nx = found_nonce;
    if (hit) found_nonce_nx = nonce_q[hit_idx];
    else if (start_ok) found_nonce_nx = '0;
  end

  // datapath registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_vec    <= '0;
      rr_ptr      <= '0;
      next_nonce  <= '0;
      last        <= '0;
      nonce_q     <= '0;
      core_issue  <= '0;
      core_abort  <= 1'b0;
      found_nonce <= '0;
    end else begin
      busy_vec    <= busy_vec_nx;
      rr_ptr      <= rr_ptr_nx;
      next_nonce  <= next_nonce_nx;
      last        <= last_nx;
      core_issue  <= issue_nx;
      core_abort  <= abort_nx;
      found_nonce <= found_nonce_nx;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (issue_nx[i]) nonce_q[i] <= cur_nonce;
      end
    end
  end

  assign core_nonce = nonce_q;

`ifdef MINE_SCHED_STATS_EN
  logic [31:0] hash_cnt;
  logic [5:0]  pc;
  logic [32:0] sum;

  // popcount of completions this cycle, saturating add
  always_comb begin
    pc = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      pc = pc + 6'(done_vec[i]);
    end
    sum = {1'b0, hash_cnt} + 33'(pc);
  end

  // completed-hash counter, restarted with each run
  always_ff @(posedge clock) begin
    if (!reset)
      hash_cnt <= '0;
    else if (start_ok)
      hash_cnt <= '0;
    else if (live && !abort)
      hash_cnt <= sum[32] ? '1 : sum[31:0];
  end

  assign hashes_done = hash_cnt;
`else
  assign hashes_done = '0;
`endif

endmodule

// File: tb/tb_mine_scheduler.sv
// tb_mine_scheduler: directed checks of issue order, hits, wrap,
// abort and reset for mine_scheduler with four cores.
module tb_mine_scheduler;
  localparam int N = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [31:0]      nonce_start = '0;
  logic [31:0]      nonce_end = '0;
  logic [N-1:0]     core_issue;
  logic [32*N-1:0]  core_nonce;
  logic             core_abort;
  logic [N-1:0]     core_done = '0;
  logic [N-1:0]     core_hit = '0;
  logic             busy;
  logic             found;
  logic             exhausted;
  logic [31:0]      found_nonce;
  logic [31:0]      hashes_done;

  mine_scheduler #(.NUM_CORES(N), .PTR_W(2)) dut (
    .clock(clock), .reset(reset),
    .start(start), .abort(abort),
    .nonce_start(nonce_start), .nonce_end(nonce_end),
    .core_issue(core_issue), .core_nonce(core_nonce),
    .core_abort(core_abort),
    .core_done(core_done), .core_hit(core_hit),
    .busy(busy), .found(found), .exhausted(exhausted),
    .found_nonce(found_nonce), .hashes_done(hashes_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cnt [N];
  logic [31:0] held [N];
  bit auto_done = 0;
  bit hit_en = 0;
  logic [31:0] hit_nonce = '0;
  int stepno = 0;
  int last_done_step = -1;
  int hit_step = -1;
  int aborts = 0;
  int log_core [$];
  logic [31:0] log_nonce [$];
  logic [31:0] exp_hd;
  int n0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    log_core.delete();
    log_nonce.delete();
    aborts = 0;
  endtask

  // one clock; then behave like the cores for the next edge
  task automatic step();
    @(posedge clock);
    #1;
    stepno++;
    start = 1'b0;
    abort = 1'b0;
    core_done = '0;
    core_hit = '0;
    if (core_abort || !reset) begin
      if (core_abort) aborts++;
      for (int i = 0; i < N; i++) cnt[i] = 0;
    end else if (auto_done) begin
      for (int i = 0; i < N; i++) begin
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            core_done[i] = 1'b1;
            last_done_step = stepno;
            if (hit_en && held[i] == hit_nonce) begin
              core_hit[i] = 1'b1;
              hit_step = stepno;
            end
          end
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (core_issue[i]) begin
        log_core.push_back(i);
        log_nonce.push_back(core_nonce[32*i +: 32]);
        held[i] = core_nonce[32*i +: 32];
        cnt[i] = 3;
      end
    end
  endtask

  task automatic go(input logic [31:0] s, input logic [31:0] e);
    nonce_start = s;
    nonce_end = e;
    start = 1'b1;
    step();
  endtask

  initial begin
    // reset state
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_found", found, 0);
    chk("rst_exh", exhausted, 0);
    chk("rst_issue", core_issue, 0);
    chk("rst_abort", core_abort, 0);
    chk("rst_fnonce", found_nonce, 0);
    chk("rst_hd", hashes_done, 0);
    reset = 1'b1;
    step();

    // full issue order 0x100..0x107
    clr();
    auto_done = 1;
    go(32'h100, 32'h107);
    chk("ord_first", core_issue, 32'h1);
    chk("ord_busy", busy, 1);
    for (int s = 0; s < 100 && !exhausted; s++) step();
    chk("ord_exh", exhausted, 1);
    chk("ord_exh_lat", stepno, last_done_step + 1);
    chk("ord_n", log_core.size(), 8);
    for (int i = 0; i < 8 && i < log_core.size(); i++) begin
      chk("ord_core", log_core[i], i % 4);
      chk("ord_nonce", log_nonce[i], 32'h100 + i);
    end
`ifdef MINE_SCHED_STATS_EN
    exp_hd = 32'd8;
`else
    exp_hd = 32'd0;
`endif
    chk("ord_hd", hashes_done, exp_hd);

    // single hit
    clr();
    hit_en = 1;
    hit_nonce = 32'h42A14695;
    go(32'h42A14690, 32'h42A1469F);
    for (int s = 0; s < 100 && !found; s++) step();
    chk("hit_found", found, 1);
    chk("hit_nonce", found_nonce, 32'h42A14695);
    chk("hit_lat", stepno, hit_step + 1);
    chk("hit_abort", core_abort, 1);
    chk("hit_noiss", core_issue, 0);
    n0 = log_core.size();
    for (int s = 0; s < 5; s++) step();
    chk("hit_abort1", aborts, 1);
    chk("hit_nomore", log_core.size(), n0);
    chk("hit_hold", found, 1);
    hit_en = 0;
    auto_done = 0;

    // simultaneous hits on cores 1 and 3
    reset = 1'b0;
    step();
    reset = 1'b1;
    clr();
    go(32'h10, 32'h13);
    step();
    step();
    step();
    chk("sim_c1", core_nonce[63:32], 32'h11);
    chk("sim_c3", core_nonce[127:96], 32'h13);
    core_done = 4'b1010;
    core_hit = 4'b1010;
    step();
    chk("sim_found", found, 1);
    chk("sim_nonce", found_nonce, 32'h11);
    chk("sim_busy", busy, 0);

    // wrap through 0xFFFFFFFF
    clr();
    go(32'hFFFFFFFE, 32'h1);
    step();
    step();
    step();
    step();
    step();
    step();
    chk("wrap_n", log_core.size(), 4);
    for (int i = 0; i < 4 && i < log_core.size(); i++) begin
      chk("wrap_core", log_core[i], i);
      chk("wrap_nonce", log_nonce[i], 32'hFFFFFFFE + i);
    end
    chk("wrap_drain", busy, 1);
    core_done = 4'hF;
    step();
    chk("wrap_exh", exhausted, 1);
    chk("wrap_idle", busy, 0);

    // abort mid-run with three cores busy
    clr();
    go(32'h200, 32'h2FF);
    step();
    step();
    chk("ab_n", log_core.size(), 3);
    abort = 1'b1;
    step();
    chk("ab_busy", busy, 0);
    chk("ab_pulse", core_abort, 1);
    chk("ab_noiss", core_issue, 0);
    step();
    chk("ab_once", core_abort, 0);
    core_done = 4'b0111;
    step();
    step();
    chk("ab_stay", busy, 0);
    chk("ab_nofound", found, 0);
    chk("ab_noexh", exhausted, 0);
    chk("ab_cnt", aborts, 1);
    chk("ab_n2", log_core.size(), 3);

    // reset during DRAIN, then a one-nonce range
    clr();
    go(32'h300, 32'h301);
    step();
    chk("rd_drain", busy, 1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rd_busy", busy, 0);
    chk("rd_abort", core_abort, 0);
    chk("rd_issue", core_issue, 0);
    chk("rd_n0", core_nonce[31:0], 0);
    chk("rd_n3", core_nonce[127:96], 0);
    chk("rd_exh", exhausted, 0);
    clr();
    go(32'h5, 32'h5);
    chk("one_issue", core_issue, 32'h1);
    chk("one_nonce", core_nonce[31:0], 32'h5);
    chk("one_busy", busy, 1);
    step();
    step();
    step();
    chk("one_n", log_core.size(), 1);
    core_done = 4'b0001;
    step();
    chk("one_exh", exhausted, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
